ws2812_decoder: RTL and testbench



---
 rtl/ws2812_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ws2812_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_decoder.sv
// ============================================================================
// Module   : ws2812_decoder
// Brief    : WS2812 single-wire receiver; pulse-width decode to 24-bit GRB words
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_decoder #(
  parameter int T1_MIN       = 7,
  parameter int HIGH_MIN     = 2,
  parameter int HIGH_MAX     = 24,
  parameter int RESET_CYCLES = 600
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN,
  output logic [7:0] o_green,
  output logic [7:0] o_red,
  output logic [7:0] o_blue,
  output logic [7:0] o_index,
  output logic       o_valid,
  output logic       o_latch,
  output logic       o_error
);

  localparam logic [4:0] c_t1_min   = 5'(T1_MIN);
  localparam logic [4:0] c_high_min = 5'(HIGH_MIN);
  localparam logic [4:0] c_high_max = 5'(HIGH_MAX);
  localparam logic [9:0] c_reset    = 10'(RESET_CYCLES);
  localparam logic [4:0] c_last_bit = 5'd23;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  logic   r_din_meta, r_din_s, r_din_d;
  logic   r_rise, r_fall;
  state_t r_state, w_state_nxt;
  logic [4:0]  r_high_cnt, w_high_nxt, w_high_inc;
  logic [9:0]  r_low_cnt, w_low_nxt, w_low_inc;
  logic [4:0]  r_bit_cnt, w_bit_nxt;
  logic [23:0] r_sr, w_sr_nxt, w_sr_shift;
  logic [7:0]  r_pix_cnt, w_pix_nxt;
  logic        w_valid, w_latch, w_error;

  // Edge flags are registered so the FSM acts two edges after din_s changes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_din_meta <= 1'b0;
      r_din_s    <= 1'b0;
      r_din_d    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_din_meta <= DIN;
      r_din_s    <= r_din_meta;
      r_din_d    <= r_din_s;
      r_rise     <= !r_din_d & r_din_s;
      r_fall     <= r_din_d & !r_din_s;
    end
  end

  assign w_high_inc = (r_high_cnt == 5'd31) ? 5'd31 : r_high_cnt + 5'd1;
  assign w_low_inc  = (r_low_cnt >= c_reset) ? c_reset : r_low_cnt + 10'd1;
  assign w_sr_shift = {r_sr[22:0], (r_high_cnt >= c_t1_min)};

  always_comb begin
    w_state_nxt = r_state;
    w_high_nxt  = r_high_cnt;
    w_low_nxt   = r_low_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_sr_nxt    = r_sr;
    w_pix_nxt   = r_pix_cnt;
    w_valid     = 1'b0;
    w_latch     = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      ST_SYNC: begin
        w_bit_nxt = 5'd0;
        if (r_din_d) begin
          w_low_nxt = 10'd0;
        end else if (w_low_inc >= c_reset) begin
          w_low_nxt   = 10'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_low_nxt = w_low_inc;
        end
      end
      ST_IDLE: begin
        if (r_rise) begin
          w_state_nxt = ST_HIGH;
          w_high_nxt  = 5'd1;
          w_bit_nxt   = 5'd0;
        end
      end
      ST_HIGH: begin
        if (r_fall) begin
          w_low_nxt = 10'd0;
          if (r_high_cnt < c_high_min) begin
            w_error     = 1'b1;
            w_bit_nxt   = 5'd0;
            w_state_nxt = ST_SYNC;
          end else begin
            w_sr_nxt    = w_sr_shift;
            w_state_nxt = ST_LOW;
            if (r_bit_cnt == c_last_bit) begin
              w_valid   = 1'b1;
              w_bit_nxt = 5'd0;
              w_pix_nxt = r_pix_cnt + 8'd1;
            end else begin
              w_bit_nxt = r_bit_cnt + 5'd1;
            end
          end
        end else if (r_high_cnt >= c_high_max) begin
          // Next count would exceed the maximum: abandon the word now
          w_error     = 1'b1;
          w_bit_nxt   = 5'd0;
          w_low_nxt   = 10'd0;
          w_state_nxt = ST_SYNC;
        end else begin
          w_high_nxt = w_high_inc;
        end
      end
      ST_LOW: begin
        if (r_rise) begin
          w_state_nxt = ST_HIGH;
          w_high_nxt  = 5'd1;
        end else if (w_low_inc >= c_reset) begin
          w_latch     = 1'b1;
          w_error     = (r_bit_cnt != 5'd0);
          w_bit_nxt   = 5'd0;
          w_pix_nxt   = 8'd0;
          w_low_nxt   = 10'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_low_nxt = w_low_inc;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_SYNC;
      r_high_cnt <= 5'd0;
      r_low_cnt  <= 10'd0;
      r_bit_cnt  <= 5'd0;
      r_sr       <= 24'd0;
      r_pix_cnt  <= 8'd0;
      o_green    <= 8'd0;
      o_red      <= 8'd0;
      o_blue     <= 8'd0;
      o_index    <= 8'd0;
      o_valid    <= 1'b0;
      o_latch    <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_high_cnt <= w_high_nxt;
      r_low_cnt  <= w_low_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_sr       <= w_sr_nxt;
      r_pix_cnt  <= w_pix_nxt;
      o_valid    <= w_valid;
      o_latch    <= w_latch;
      o_error    <= w_error;
      if (w_valid) begin
        o_green <= w_sr_nxt[23:16];
        o_red   <= w_sr_nxt[15:8];
        o_blue  <= w_sr_nxt[7:0];
        o_index <= r_pix_cnt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ws2812_decoder.sv
// ============================================================================
// Module   : tb_ws2812_decoder
// Brief    : randomized pulse-train bench with a pulse-list decode model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_decoder;

  localparam int T1_MIN       = 7;
  localparam int HIGH_MIN     = 2;
  localparam int HIGH_MAX     = 24;
  localparam int RESET_CYCLES = 600;
  localparam int GAP          = 650;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DIN = 1'b0;
  logic [7:0] o_green, o_red, o_blue, o_index;
  logic       o_valid, o_latch, o_error;

  ws2812_decoder #(
    .T1_MIN(T1_MIN), .HIGH_MIN(HIGH_MIN), .HIGH_MAX(HIGH_MAX), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN),
    .o_green(o_green), .o_red(o_red), .o_blue(o_blue), .o_index(o_index),
    .o_valid(o_valid), .o_latch(o_latch), .o_error(o_error)
  );

  always #5 CLK = ~CLK;

  // kind = {valid, latch, error}; word holds the colour expected on the outputs
  typedef struct {
    logic [2:0]  kind;
    logic [23:0] word;
    logic [7:0]  idx;
  } ev_t;

  ev_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          m_synced;
  int          m_bits;
  logic [23:0] m_sr;
  logic [7:0]  m_pix;
  logic [23:0] m_last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [23:0] word, input logic [7:0] idx);
    ev_t e;
    e.kind = kind; e.word = word; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_synced = 1'b0; m_bits = 0; m_sr = '0; m_pix = '0; m_last = '0;
  endtask

  // One high pulse of h cycles followed by l low cycles, decoded from the width rules
  task automatic model_pulse(input int h, input int l);
    if (!m_synced) begin
      if (l >= RESET_CYCLES) m_synced = 1'b1;
      return;
    end
    if (h < HIGH_MIN || h > HIGH_MAX) begin
      push_ev(3'b001, m_last, 8'd0);
      m_synced = (l >= RESET_CYCLES);
      m_bits = 0;
      return;
    end
    m_sr = {m_sr[22:0], (h >= T1_MIN)};
    m_bits++;
    if (m_bits == 24) begin
      m_last = m_sr;
      push_ev(3'b100, m_sr, m_pix);
      m_pix++;
      m_bits = 0;
    end
    if (l >= RESET_CYCLES) begin
      push_ev({2'b01, (m_bits != 0)}, m_last, 8'd0);
      m_pix = 0;
      m_bits = 0;
    end
  endtask

  task automatic pulse(input int h, input int l);
    model_pulse(h, l);
    DIN = 1'b1;
    repeat (h) @(negedge CLK);
    DIN = 1'b0;
    repeat (l) @(negedge CLK);
  endtask

  task automatic gap(input int l);
    if (!m_synced && l >= RESET_CYCLES) m_synced = 1'b1;
    DIN = 1'b0;
    repeat (l) @(negedge CLK);
  endtask

  // mode 0: random widths, 1: fixed 5/10 and 10/5, 2: threshold widths 6 and 7
  task automatic send_bits(input logic [23:0] word, input int nbits, input int mode, input int last_low);
    int h, l;
    for (int i = 23; i > 23 - nbits; i--) begin
      case (mode)
        1: begin h = word[i] ? 10 : 5; l = word[i] ? 5 : 10; end
        2: begin h = word[i] ? T1_MIN : T1_MIN - 1; l = $urandom_range(8, 1); end
        default: begin
          h = word[i] ? $urandom_range(HIGH_MAX, T1_MIN) : $urandom_range(T1_MIN - 1, HIGH_MIN);
          l = $urandom_range(12, 1);
        end
      endcase
      if (i == 24 - nbits && last_low > 0) l = last_low;
      pulse(h, l);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && (o_valid || o_latch || o_error)) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", {29'd0, o_valid, o_latch, o_error}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_val("strobe_kind", {29'd0, o_valid, o_latch, o_error}, {29'd0, e.kind});
        check_val("colour", {8'd0, o_green, o_red, o_blue}, {8'd0, e.word});
        if (e.kind[2]) check_val("index", {24'd0, o_index}, {24'd0, e.idx});
      end
    end
  end

  logic [23:0] frame[10];

  initial begin
    int n;
    frame = '{24'h004000, 24'h400000, 24'h202000, 24'h000002, 24'h100010,
              24'h010100, 24'h800001, 24'h000800, 24'hFFFFFF, 24'h080880};
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    check_val("rst_green", {24'd0, o_green}, 32'd0);
    check_val("rst_red",   {24'd0, o_red},   32'd0);
    check_val("rst_blue",  {24'd0, o_blue},  32'd0);
    check_val("rst_index", {24'd0, o_index}, 32'd0);
    check_val("rst_strobes", {29'd0, o_valid, o_latch, o_error}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    gap(GAP);

    send_bits(24'h400000, 24, 1, GAP);                       // single pixel
    for (int p = 0; p < 10; p++) send_bits(frame[p], 24, 0, (p == 9) ? GAP : 0);
    for (int p = 0; p < 2; p++) send_bits($urandom, 24, 0, (p == 1) ? GAP : 0);
    send_bits(24'hA5C3F0, 24, 2, GAP);                       // 6 -> '0', 7 -> '1'
    for (int i = 0; i < 24; i++) pulse(i[0] ? HIGH_MAX : HIGH_MIN, (i == 23) ? GAP : 1);

    send_bits(24'h123456, 5, 0, 0);                          // glitch mid-word
    pulse(1, GAP);
    send_bits(24'h0F0F0F, 24, 0, GAP);
    send_bits(24'hABCDEF, 3, 0, 0);                          // over-long pulse
    pulse(HIGH_MAX + 1, GAP);
    send_bits(24'h55AA55, 24, 0, GAP);

    send_bits(24'hC0FFEE, 12, 0, GAP);                       // partial word
    send_bits(24'h00FF00, 24, 0, GAP);

    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(4, 1);
      for (int p = 0; p < n; p++) send_bits($urandom, 24, 0, (p == n - 1) ? GAP : 0);
    end

    send_bits(24'h777777, 24, 0, 0);                         // reset after bit 10
    send_bits(24'h3C3C3C, 10, 0, 0);
    DIN = 1'b1;
    repeat (3) @(negedge CLK);
    check_val("pre_reset_drain", exp_q.size(), 32'd0);
    RST_N = 1'b0;
    #1;
    check_val("mid_rst_colour", {8'd0, o_green, o_red, o_blue}, 32'd0);
    check_val("mid_rst_index", {24'd0, o_index}, 32'd0);
    check_val("mid_rst_strobes", {29'd0, o_valid, o_latch, o_error}, 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    DIN = 1'b0;
    repeat (4) @(negedge CLK);
    send_bits(24'h3C3C3C, 14, 0, 0);
    send_bits(24'h999999, 24, 0, GAP);
    send_bits(24'h246801, 24, 0, GAP);

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check_val("final_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
